fb_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single framebuffer write port among NUM_REQ RISC-V cores. Each core's framebuffer write is fire-and-forget, with no stall input, so every requester gets a small synchronous FIFO. The arbiter drains those FIFOs, one pixel per cycle, into a registered output stage with a valid/ready handshake toward the framebuffer. It sits between the cores' fb_wr_* outputs and the framebuffer write port.

---
 rtl/display_processor_pkg.sv | 19 +
 rtl/fb_wr_fifo.sv | 50 +++++
 rtl/fb_write_arbiter.sv | 125 ++++++++++++
 tb/tb_fb_write_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_processor_pkg.sv
// Shared display-processor types and default geometry used by the framebuffer write arbiter.
package display_processor_pkg;

  localparam int unsigned DEFAULT_RESOLUTION_X   = 400;
  localparam int unsigned DEFAULT_RESOLUTION_Y   = 300;
  localparam int unsigned DEFAULT_PALETTE_LENGTH = 256;
  localparam int unsigned FB_ARB_MAX_REQ         = 8;

  localparam int unsigned PXL_XW = $clog2(DEFAULT_RESOLUTION_X);
  localparam int unsigned PXL_YW = $clog2(DEFAULT_RESOLUTION_Y);
  localparam int unsigned PXL_VW = $clog2(DEFAULT_PALETTE_LENGTH);

  typedef struct packed {
    logic [PXL_XW-1:0] x;
    logic [PXL_YW-1:0] y;
    logic [PXL_VW-1:0] value;
  } fb_arb_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous single-clock FIFO holding one core's pending framebuffer writes.
module fb_wr_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; valid data is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter merging per-core pixel FIFOs into one registered framebuffer write port.
// Optional FB_WRITE_ARBITER_BOUNDS_CHECK_EN drops out-of-range coordinates at enqueue.
module fb_write_arbiter
  import display_processor_pkg::*;
#(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned RESOLUTION_X      = DEFAULT_RESOLUTION_X,
  parameter int unsigned RESOLUTION_Y      = DEFAULT_RESOLUTION_Y,
  parameter int unsigned PALETTE_LENGTH    = DEFAULT_PALETTE_LENGTH,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned ALMOST_FULL_LEVEL = 3
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_REQ-1:0]                         req_wr_en,
  input  logic [NUM_REQ*$clog2(RESOLUTION_X)-1:0]    req_pxl_x,
  input  logic [NUM_REQ*$clog2(RESOLUTION_Y)-1:0]    req_pxl_y,
  input  logic [NUM_REQ*$clog2(PALETTE_LENGTH)-1:0]  req_pxl_value,
  output logic [NUM_REQ-1:0]                         req_almost_full,
  output logic [NUM_REQ-1:0]                         req_overflow,
  input  logic [NUM_REQ-1:0]                         overflow_clr,
  output logic                                       fb_wr_en,
  input  logic                                       fb_wr_ready,
  output logic [$clog2(RESOLUTION_X)-1:0]            fb_wr_pxl_x,
  output logic [$clog2(RESOLUTION_Y)-1:0]            fb_wr_pxl_y,
  output logic [$clog2(PALETTE_LENGTH)-1:0]          fb_wr_pxl_value
);

  localparam int unsigned XW = $clog2(RESOLUTION_X);
  localparam int unsigned YW = $clog2(RESOLUTION_Y);
  localparam int unsigned VW = $clog2(PALETTE_LENGTH);
  localparam int unsigned EW = XW + YW + VW;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] drop;
  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] in_range;
  logic [EW-1:0]      head [NUM_REQ];

  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      grant_idx;
  logic [GW-1:0]      scan_idx;
  logic               grant_valid;
  logic               load_ok;

  assign load_ok = !fb_wr_en || fb_wr_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [VW-1:0] v;
    logic [CW-1:0] count;

    assign x = req_pxl_x[i*XW +: XW];
    assign y = req_pxl_y[i*YW +: YW];
    assign v = req_pxl_value[i*VW +: VW];

`ifdef FB_WRITE_ARBITER_BOUNDS_CHECK_EN
    assign in_range[i] = (32'(x) < RESOLUTION_X) && (32'(y) < RESOLUTION_Y);
`else
    assign in_range[i] = 1'b1;
`endif

    // A full FIFO still accepts a write when its head leaves in the same cycle.
    assign push[i] = req_wr_en[i] && in_range[i] && (!full[i] || pop[i]);
    assign drop[i] = req_wr_en[i] && in_range[i] && full[i] && !pop[i];
    assign pop[i]  = load_ok && grant_valid && (grant_idx == GW'(i));
    assign req_almost_full[i] = (count >= CW'(ALMOST_FULL_LEVEL));

    fb_wr_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (EW)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .din   ({x, y, v}),
      .pop   (pop[i]),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (count)
    );
  end

  // Scan downward so the nearest non-empty FIFO after last_grant wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      scan_idx = GW'((32'(last_grant) + k) % NUM_REQ);
      if (!empty[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Output stage, round-robin pointer and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fb_wr_en        <= 1'b0;
      fb_wr_pxl_x     <= '0;
      fb_wr_pxl_y     <= '0;
      fb_wr_pxl_value <= '0;
      last_grant      <= GW'(NUM_REQ - 1);
      req_overflow    <= '0;
    end else begin
      if (load_ok) begin
        fb_wr_en <= grant_valid;
        if (grant_valid) begin
          {fb_wr_pxl_x, fb_wr_pxl_y, fb_wr_pxl_value} <= head[grant_idx];
          last_grant <= grant_idx;
        end
      end
      req_overflow <= (req_overflow & ~overflow_clr) | drop;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: latency, fairness, backpressure, full+pop, reset, bounds.
module tb_fb_write_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned XW = 9;
  localparam int unsigned YW = 9;
  localparam int unsigned VW = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NR-1:0]      req_wr_en = '0;
  logic [NR*XW-1:0]   req_pxl_x = '0;
  logic [NR*YW-1:0]   req_pxl_y = '0;
  logic [NR*VW-1:0]   req_pxl_value = '0;
  logic [NR-1:0]      req_almost_full;
  logic [NR-1:0]      req_overflow;
  logic [NR-1:0]      overflow_clr = '0;
  logic               fb_wr_en;
  logic               fb_wr_ready = 1'b0;
  logic [XW-1:0]      fb_wr_pxl_x;
  logic [YW-1:0]      fb_wr_pxl_y;
  logic [VW-1:0]      fb_wr_pxl_value;

  int total = 0;
  int bad   = 0;

  logic        cap_en = 1'b0;
  logic [31:0] cap_q[$];

  fb_write_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req_wr_en       (req_wr_en),
    .req_pxl_x       (req_pxl_x),
    .req_pxl_y       (req_pxl_y),
    .req_pxl_value   (req_pxl_value),
    .req_almost_full (req_almost_full),
    .req_overflow    (req_overflow),
    .overflow_clr    (overflow_clr),
    .fb_wr_en        (fb_wr_en),
    .fb_wr_ready     (fb_wr_ready),
    .fb_wr_pxl_x     (fb_wr_pxl_x),
    .fb_wr_pxl_y     (fb_wr_pxl_y),
    .fb_wr_pxl_value (fb_wr_pxl_value)
  );

  always #5 clk = ~clk;

  // Record every accepted transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (cap_en && fb_wr_en && fb_wr_ready)
      cap_q.push_back(32'({fb_wr_pxl_x, fb_wr_pxl_y, fb_wr_pxl_value}));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int x, input int y, input int v);
    return 32'({XW'(x), YW'(y), VW'(v)});
  endfunction

  function automatic logic [31:0] cap_at(input int k);
    return (k < cap_q.size()) ? cap_q[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] out_word();
    return 32'({fb_wr_en, fb_wr_pxl_x, fb_wr_pxl_y, fb_wr_pxl_value});
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input int x, input int y, input int v);
    req_wr_en[i] = 1'b1;
    req_pxl_x[i*XW +: XW] = XW'(x);
    req_pxl_y[i*YW +: YW] = YW'(y);
    req_pxl_value[i*VW +: VW] = VW'(v);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    req_wr_en    = '0;
    overflow_clr = '0;
    fb_wr_ready  = 1'b0;
    cap_en       = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_out", out_word(), 32'h0);
    check("rst_afull", 32'(req_almost_full), 32'h0);
    check("rst_ovf", 32'(req_overflow), 32'h0);

    // Single write: fb_wr_en high exactly one cycle, two cycles after the strobe
    fb_wr_ready = 1'b1;
    set_req(2, 10, 20, 'h5A);
    step();
    req_wr_en = '0;
    check("single_lat1", 32'(fb_wr_en), 32'h0);
    step();
    check("single_out", out_word(), (32'h1 << 26) | pk(10, 20, 'h5A));
    step();
    check("single_drop", 32'(fb_wr_en), 32'h0);
    check("single_ovf", 32'(req_overflow), 32'h0);

    // Fairness: four requesters, three pixels each
    do_reset();
    fb_wr_ready = 1'b1;
    cap_q.delete();
    cap_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) set_req(i, i * 16 + c, c, i);
      step();
    end
    req_wr_en = '0;
    step(14);
    cap_en = 1'b0;
    check("fair_cnt", 32'(cap_q.size()), 32'd12);
    for (int k = 0; k < 12; k++)
      check("fair_seq", cap_at(k), pk((k % 4) * 16 + k / 4, k / 4, k % 4));

    // Backpressure on requester 1
    do_reset();
    fb_wr_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 6) set_req(1, k + 1, k + 2, 'h10 + k);
      else req_wr_en = '0;
      step();
      check("bp_afull", 32'(req_almost_full[1]), 32'(k >= 3));
      check("bp_ovf", 32'(req_overflow[1]), 32'(k >= 5));
      if (k >= 1) check("bp_hold", out_word(), (32'h1 << 26) | pk(1, 2, 'h10));
    end
    overflow_clr = 4'b0010;
    step();
    overflow_clr = '0;
    check("bp_clr", 32'(req_overflow), 32'h0);
    cap_q.delete();
    cap_en = 1'b1;
    fb_wr_ready = 1'b1;
    step(5);
    cap_en = 1'b0;
    check("bp_b2b_cnt", 32'(cap_q.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      check("bp_drain", cap_at(k), pk(k + 1, k + 2, 'h10 + k));
    check("bp_idle", 32'(fb_wr_en), 32'h0);
    check("bp_afull_clr", 32'(req_almost_full[1]), 32'h0);

    // Full FIFO popped while a new write arrives
    do_reset();
    fb_wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(0, k, k, 'h20 + k);
      step();
    end
    req_wr_en = '0;
    check("fp_afull", 32'(req_almost_full[0]), 32'h1);
    check("fp_ovf0", 32'(req_overflow[0]), 32'h0);
    cap_q.delete();
    cap_en = 1'b1;
    fb_wr_ready = 1'b1;
    set_req(0, 5, 5, 'h25);
    step();
    req_wr_en = '0;
    check("fp_ovf", 32'(req_overflow[0]), 32'h0);
    check("fp_afull_hold", 32'(req_almost_full[0]), 32'h1);
    step(6);
    cap_en = 1'b0;
    check("fp_cnt", 32'(cap_q.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      check("fp_order", cap_at(k), pk(k, k, 'h20 + k));

    // Reset mid-stream discards everything
    do_reset();
    fb_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 100 + i, 50 + i, 'h40 + i);
    step();
    req_wr_en = '0;
    step();
    check("mr_busy", out_word(), (32'h1 << 26) | pk(100, 50, 'h40));
    reset = 1'b0;
    step();
    check("mr_out", out_word(), 32'h0);
    check("mr_afull", 32'(req_almost_full), 32'h0);
    check("mr_ovf", 32'(req_overflow), 32'h0);
    reset = 1'b1;
    fb_wr_ready = 1'b1;
    cap_q.delete();
    cap_en = 1'b1;
    step(10);
    cap_en = 1'b0;
    check("mr_stale", 32'(cap_q.size()), 32'd0);
    check("mr_idle", 32'(fb_wr_en), 32'h0);

    // Coordinate bounds
    do_reset();
    fb_wr_ready = 1'b1;
    cap_q.delete();
    cap_en = 1'b1;
    set_req(3, 400, 0, 1);
    step();
    set_req(3, 0, 300, 2);
    step();
    set_req(3, 399, 299, 3);
    step();
    req_wr_en = '0;
    step(6);
    cap_en = 1'b0;
    check("bc_ovf", 32'(req_overflow), 32'h0);
`ifdef FB_WRITE_ARBITER_BOUNDS_CHECK_EN
    check("bc_cnt", 32'(cap_q.size()), 32'd1);
    check("bc_keep", cap_at(0), pk(399, 299, 3));
`else
    check("bc_cnt", 32'(cap_q.size()), 32'd3);
    check("bc_x", cap_at(0), pk(400, 0, 1));
    check("bc_y", cap_at(1), pk(0, 300, 2));
    check("bc_keep", cap_at(2), pk(399, 299, 3));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
